// File: rtl/udma_spim_cmd_seq.sv
// uDMA SPI command sequencer: one-entry registered output stage plus hardware repeat loops.
// Commands recorded between RPT and RPT_END are replayed from a local buffer.
//
// state    | meaning
// S_PASS   | forward input words, watch for RPT
// S_RECORD | forward input words and store them in the loop buffer
// S_REPLAY | input stalled, loop buffer replayed remaining times
module udma_spim_cmd_seq #(
   parameter int         LOOP_DEPTH     = 8,
   parameter logic [3:0] RPT_OPCODE     = 4'hA,
   parameter logic [3:0] RPT_END_OPCODE = 4'hB
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [31:0] cmd_data_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   output logic [31:0] udma_cmd_o,
   output logic        udma_cmd_valid_o,
   input  logic        udma_cmd_ready_i,
   input  logic        cfg_clr_i,
   output logic        busy_o,
   output logic        rpt_err_o
);

   localparam int PW = $clog2(LOOP_DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic [1:0] {S_PASS, S_RECORD, S_REPLAY} state_t;

   state_t         state_q;
   logic [LW-1:0]  len_q;
   logic [PW-1:0]  rd_ptr_q;
   logic [15:0]    count_q;
   logic [15:0]    remaining_q;
   logic [31:0]    loop_buf [LOOP_DEPTH];

   logic [3:0] opcode;
   logic       slot_free;
   logic       accept;
   logic       is_rpt;
   logic       is_end;
   logic       buf_full;
   logic       rd_last;
   logic       buf_we;

   assign opcode      = cmd_data_i[31:28];
   assign is_rpt      = (opcode == RPT_OPCODE);
   assign is_end      = (opcode == RPT_END_OPCODE);
   assign slot_free   = ~udma_cmd_valid_o | udma_cmd_ready_i;
   assign cmd_ready_o = slot_free & (state_q != S_REPLAY) & ~cfg_clr_i;
   assign accept      = cmd_valid_i & cmd_ready_o;
   assign buf_full    = (len_q == LW'(LOOP_DEPTH));
   assign rd_last     = ({1'b0, rd_ptr_q} == (len_q - LW'(1)));
   assign buf_we      = accept & (state_q == S_RECORD) & ~is_rpt & ~is_end & ~buf_full;
   assign busy_o      = (state_q != S_PASS) | udma_cmd_valid_o;

   // Buffer needs no reset: len_q alone decides which entries are meaningful.
   always_ff @(posedge clk_i) begin
      if (buf_we) loop_buf[len_q[PW-1:0]] <= cmd_data_i;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q          <= S_PASS;
         len_q            <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         remaining_q      <= '0;
         udma_cmd_o       <= '0;
         udma_cmd_valid_o <= 1'b0;
         rpt_err_o        <= 1'b0;
      end else if (cfg_clr_i) begin
         state_q          <= S_PASS;
         len_q            <= '0;
         rd_ptr_q         <= '0;
         remaining_q      <= '0;
         udma_cmd_valid_o <= 1'b0;
         rpt_err_o        <= 1'b0;
      end else begin
         // Drop valid once consumed; any load below overrides this.
         if (slot_free) udma_cmd_valid_o <= 1'b0;
         case (state_q)
            S_PASS: begin
               if (accept) begin
                  if (is_rpt) begin
                     count_q <= cmd_data_i[15:0];
                     len_q   <= '0;
                     state_q <= S_RECORD;
                  end else if (is_end) begin
                     rpt_err_o <= 1'b1;
                  end else begin
                     udma_cmd_o       <= cmd_data_i;
                     udma_cmd_valid_o <= 1'b1;
                  end
               end
            end
            S_RECORD: begin
               if (accept) begin
                  if (is_rpt) begin
                     rpt_err_o <= 1'b1;
                  end else if (is_end) begin
                     if (count_q <= 16'd1 || len_q == '0) begin
                        state_q <= S_PASS;
                     end else begin
                        remaining_q <= count_q - 16'd1;
                        rd_ptr_q    <= '0;
                        state_q     <= S_REPLAY;
                     end
                  end else begin
                     udma_cmd_o       <= cmd_data_i;
                     udma_cmd_valid_o <= 1'b1;
                     if (buf_full) begin
                        rpt_err_o <= 1'b1;
                        state_q   <= S_PASS;
                     end else begin
                        len_q <= len_q + LW'(1);
                     end
                  end
               end
            end
            S_REPLAY: begin
               if (slot_free) begin
                  udma_cmd_o       <= loop_buf[rd_ptr_q];
                  udma_cmd_valid_o <= 1'b1;
                  if (rd_last) begin
                     rd_ptr_q    <= '0;
                     remaining_q <= remaining_q - 16'd1;
                     if (remaining_q == 16'd1) state_q <= S_PASS;
                  end else begin
                     rd_ptr_q <= rd_ptr_q + PW'(1);
                  end
               end
            end
            default: state_q <= S_PASS;
         endcase
      end
   end

endmodule

// File: tb/tb_udma_spim_cmd_seq.sv
// Bench for udma_spim_cmd_seq: directed cases plus random command streams
// compared against a stream-level reference of the repeat-loop rules.
module tb_udma_spim_cmd_seq;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic [31:0] cmd_data_i = '0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [31:0] udma_cmd_o;
   logic        udma_cmd_valid_o;
   logic        udma_cmd_ready_i = 1'b0;
   logic        cfg_clr_i = 1'b0;
   logic        busy_o;
   logic        rpt_err_o;

   udma_spim_cmd_seq dut (
      .clk_i            (clk_i),
      .rstn_i           (rstn_i),
      .cmd_data_i       (cmd_data_i),
      .cmd_valid_i      (cmd_valid_i),
      .cmd_ready_o      (cmd_ready_o),
      .udma_cmd_o       (udma_cmd_o),
      .udma_cmd_valid_o (udma_cmd_valid_o),
      .udma_cmd_ready_i (udma_cmd_ready_i),
      .cfg_clr_i        (cfg_clr_i),
      .busy_o           (busy_o),
      .rpt_err_o        (rpt_err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] in_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   logic        exp_err;

   logic        s_acc, s_valid, s_rdy_o, s_busy, s_err;
   logic [31:0] s_cmd;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_cmd = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic rr(input int pct);
      return ($urandom_range(0, 99) < pct);
   endfunction

   function automatic logic [31:0] plain_word();
      logic [31:0] w;
      do w = $urandom; while (w[31:28] == 4'hA || w[31:28] == 4'hB);
      return w;
   endfunction

   // One clock: drive at negedge, sample 1 ns before the next posedge.
   task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic c);
      @(negedge clk_i);
      cmd_valid_i      = v;
      cmd_data_i       = d;
      udma_cmd_ready_i = r;
      cfg_clr_i        = c;
      #4;
      s_valid = udma_cmd_valid_o;
      s_cmd   = udma_cmd_o;
      s_rdy_o = cmd_ready_o;
      s_busy  = busy_o;
      s_err   = rpt_err_o;
      s_acc   = v & cmd_ready_o;
      if (prev_stall) begin
         check("hold_valid", s_valid, 1);
         check("hold_data", s_cmd, prev_cmd);
      end
      if (s_valid && r) got_q.push_back(s_cmd);
      prev_stall = s_valid & ~r & ~c;
      prev_cmd   = s_cmd;
   endtask

   task automatic send_word(input logic [31:0] d, input int pct);
      int n = 0;
      do begin
         cycle(1'b1, d, rr(pct), 1'b0);
         n++;
      end while (!s_acc && n < 300);
      if (!s_acc) check("send_timeout", s_acc, 1);
   endtask

   task automatic send_all(input int pct);
      foreach (in_q[i]) begin
         if ($urandom_range(0, 3) == 0) cycle(1'b0, '0, rr(pct), 1'b0);
         send_word(in_q[i], pct);
      end
   endtask

   task automatic drain(input int pct);
      int n = 0;
      do begin
         cycle(1'b0, '0, rr(pct), 1'b0);
         n++;
      end while (s_busy && n < 3000);
      check("drain_busy", s_busy, 0);
   endtask

   task automatic clr_pulse();
      cycle(1'b0, '0, 1'b1, 1'b1);
      got_q.delete();
      in_q.delete();
   endtask

   // Reference: the loop rules applied to the accepted word stream, no timing.
   task automatic run_model();
      int          st = 0;
      logic [15:0] cnt = '0;
      logic [31:0] body[$];
      exp_q.delete();
      exp_err = 1'b0;
      foreach (in_q[i]) begin
         logic [31:0] w = in_q[i];
         if (st == 0) begin
            if (w[31:28] == 4'hA) begin
               st = 1; cnt = w[15:0]; body.delete();
            end else if (w[31:28] == 4'hB) exp_err = 1'b1;
            else exp_q.push_back(w);
         end else begin
            if (w[31:28] == 4'hA) exp_err = 1'b1;
            else if (w[31:28] == 4'hB) begin
               st = 0;
               if (cnt > 1 && body.size() > 0)
                  for (int r = 1; r < cnt; r++)
                     foreach (body[j]) exp_q.push_back(body[j]);
            end else begin
               exp_q.push_back(w);
               if (body.size() == 8) begin
                  exp_err = 1'b1; st = 0;
               end else body.push_back(w);
            end
         end
      end
   endtask

   task automatic compare_out();
      int n;
      run_model();
      check("out_count", got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check("out_word", got_q[i], exp_q[i]);
      check("rpt_err", s_err, exp_err);
   endtask

   initial begin
      repeat (3) @(negedge clk_i);
      rstn_i = 1'b1;

      // Reset state
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("rst_valid", s_valid, 0);
      check("rst_cmd", s_cmd, 0);
      check("rst_err", s_err, 0);
      check("rst_busy", s_busy, 0);
      check("rst_ready", s_rdy_o, 1);

      // Passthrough with one-cycle latency
      got_q.delete();
      cycle(1'b1, 32'h1000_0001, 1'b1, 1'b0);
      check("pt_acc0", s_acc, 1);
      cycle(1'b1, 32'h2000_0002, 1'b1, 1'b0);
      check("pt_acc1", s_acc, 1);
      check("pt_valid0", s_valid, 1);
      check("pt_cmd0", s_cmd, 32'h1000_0001);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("pt_ready", s_rdy_o, 1);
      check("pt_cmd1", s_cmd, 32'h2000_0002);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("pt_idle", s_valid, 0);

      // Repeat loop count=3, two words
      clr_pulse();
      in_q = '{32'hA000_0003, 32'h6000_0010, 32'h7000_0020, 32'hB000_0000};
      send_all(100);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("replay_stall", s_rdy_o, 0);
      drain(100);
      check("rpt_len6", got_q.size(), 6);
      compare_out();

      // Degenerate loops
      clr_pulse();
      in_q = '{32'hA000_0000, 32'h6000_0010, 32'hB000_0000};
      send_all(100); drain(100);
      check("cnt0_len", got_q.size(), 1);
      compare_out();
      clr_pulse();
      in_q = '{32'hA000_0005, 32'hB000_0000};
      send_all(100); drain(100);
      check("empty_len", got_q.size(), 0);
      compare_out();

      // Overflow of an 8-entry buffer
      clr_pulse();
      in_q.push_back(32'hA000_0002);
      for (int i = 0; i < 9; i++) in_q.push_back(32'h1000_0100 + i);
      in_q.push_back(32'hB000_0000);
      send_all(100); drain(100);
      check("ovf_len", got_q.size(), 9);
      check("ovf_err", s_err, 1);
      compare_out();

      // Backpressure during replay
      clr_pulse();
      in_q = '{32'hA000_0003, 32'h6000_0010, 32'h7000_0020, 32'hB000_0000};
      send_all(100);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      repeat (5) cycle(1'b0, '0, 1'b0, 1'b0);
      drain(100);
      compare_out();

      // Clear mid-replay, with rpt_err_o set beforehand
      clr_pulse();
      in_q = '{32'hB000_0000, 32'hA000_0004, 32'h6000_0010, 32'h7000_0020, 32'hB000_0000};
      send_all(100);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("clr_pre_err", s_err, 1);
      check("clr_pre_busy", s_busy, 1);
      cycle(1'b1, 32'h3000_0033, 1'b1, 1'b1);
      check("clr_no_acc", s_acc, 0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("clr_valid", s_valid, 0);
      check("clr_busy", s_busy, 0);
      check("clr_err", s_err, 0);
      cycle(1'b1, 32'h4000_0044, 1'b1, 1'b0);
      check("post_clr_acc", s_acc, 1);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("post_clr_valid", s_valid, 1);
      check("post_clr_cmd", s_cmd, 32'h4000_0044);
      drain(100);

      // Random command streams
      for (int t = 0; t < 12; t++) begin
         int pct;
         clr_pulse();
         pct = $urandom_range(40, 100);
         for (int s = 0, ns = $urandom_range(1, 4); s < ns; s++) begin
            int k = $urandom_range(0, 9);
            if (k < 3) in_q.push_back(plain_word());
            else if (k == 3) in_q.push_back(32'hB000_0000);
            else begin
               in_q.push_back({4'hA, 12'($urandom), 16'($urandom_range(0, 4))});
               for (int j = 0, nb = $urandom_range(0, 10); j < nb; j++) begin
                  if ($urandom_range(0, 15) == 0)
                     in_q.push_back({4'hA, 12'($urandom), 16'($urandom_range(0, 4))});
                  else in_q.push_back(plain_word());
               end
               in_q.push_back({4'hB, 28'($urandom)});
            end
         end
         send_all(pct);
         drain(pct);
         compare_out();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
